// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered execute-stage ALU with valid/ready handshakes on both
//            sides, an iterative shift-add unsigned multiplier and a
//            persistent {Z,V,N} flag register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int DSIZE = 16,   // datapath width, even and >= 4
    parameter int SHW   = 4     // shift amount width, clog2(DSIZE)
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    input  logic [3:0]       op,
    input  logic [SHW-1:0]   imm,
    input  logic             update,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out,
    output logic [2:0]       flag        // {Z,V,N}
);

    localparam int H   = DSIZE / 2;
    localparam int MSB = DSIZE - 1;

    localparam logic [0:0] c_st_idle     = 1'b0;
    localparam logic [0:0] c_st_mul_busy = 1'b1;

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_sll = 4'd4;
    localparam logic [3:0] c_op_srl = 4'd5;
    localparam logic [3:0] c_op_sra = 4'd6;
    localparam logic [3:0] c_op_rl  = 4'd7;
    localparam logic [3:0] c_op_lhb = 4'd8;
    localparam logic [3:0] c_op_llb = 4'd9;
    localparam logic [3:0] c_op_mul = 4'd10;

    // Number of shift-add steps; the counter is one bit wider than SHW so it
    // can hold DSIZE itself as the "all steps done" value.
    localparam logic [SHW:0] c_mul_steps = (SHW + 1)'(DSIZE);

    // State registers and their next-state values
    logic [0:0]         state_q,     state_d;
    logic [SHW:0]       cnt_q,       cnt_d;
    logic [2*DSIZE-1:0] acc_q,       acc_d;
    logic [DSIZE-1:0]   mcand_q,     mcand_d;
    logic [DSIZE-1:0]   mplier_q,    mplier_d;
    logic               mupd_q,      mupd_d;
    logic [DSIZE-1:0]   out_q,       out_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         flag_q,      flag_d;

    // Combinational helpers
    logic               w_out_free;
    logic               w_accept;
    logic               w_mul_done;
    logic [DSIZE:0]     w_sum;
    logic [2*DSIZE-1:0] w_rot;
    logic [DSIZE-1:0]   w_alu_res;
    logic [2:0]         w_alu_flags;
    logic               w_alu_sets;

    // The output slot is free when empty or being drained this cycle
    assign w_out_free = !out_valid_q || out_ready;
    assign in_ready   = (state_q == c_st_idle) && w_out_free;
    assign w_accept   = in_valid && in_ready;
    assign w_mul_done = (state_q == c_st_mul_busy) && (cnt_q == c_mul_steps);

    // Rotate via a doubled operand so imm=0 never needs a shift by DSIZE
    assign w_rot = {a, a} << imm;

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign w_sum = {1'b0, acc_q[2*DSIZE-1:DSIZE]}
                 + {1'b0, (mplier_q[0] ? mcand_q : {DSIZE{1'b0}})};

    // Single-cycle ALU result and the flags it would write
    always_comb begin
        w_alu_res   = '0;
        w_alu_flags = flag_q;
        w_alu_sets  = 1'b0;
        case (op)
            c_op_add: begin
                w_alu_res   = a + b;
                w_alu_sets  = 1'b1;
                w_alu_flags = {w_alu_res == '0,
                               (a[MSB] == b[MSB]) && (w_alu_res[MSB] != a[MSB]),
                               w_alu_res[MSB]};
            end
            c_op_sub: begin
                w_alu_res   = a - b;
                w_alu_sets  = 1'b1;
                w_alu_flags = {w_alu_res == '0,
                               (a[MSB] != b[MSB]) && (w_alu_res[MSB] != a[MSB]),
                               w_alu_res[MSB]};
            end
            c_op_and: begin
                w_alu_res   = a & b;
                w_alu_sets  = 1'b1;
                w_alu_flags = {w_alu_res == '0, 1'b0, w_alu_res[MSB]};
            end
            c_op_or: begin
                w_alu_res   = a | b;
                w_alu_sets  = 1'b1;
                w_alu_flags = {w_alu_res == '0, 1'b0, w_alu_res[MSB]};
            end
            c_op_sll: w_alu_res = a << imm;
            c_op_srl: w_alu_res = a >> imm;
            c_op_sra: w_alu_res = DSIZE'($signed(a) >>> imm);
            c_op_rl:  w_alu_res = w_rot[2*DSIZE-1:DSIZE];
            c_op_lhb: w_alu_res = {b[H-1:0], a[H-1:0]};
            c_op_llb: w_alu_res = {a[DSIZE-1:H], b[H-1:0]};
            default:  w_alu_res = '0;   // undefined ops (MUL never takes this path)
        endcase
    end

    // Next-state logic for the handshake, multiplier FSM, result and flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mupd_d      = mupd_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        flag_d      = flag_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    if (op == c_op_mul) begin
                        state_d  = c_st_mul_busy;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        mupd_d   = update;
                    end else begin
                        out_d       = w_alu_res;
                        out_valid_d = 1'b1;
                        if (update && w_alu_sets) begin
                            flag_d = w_alu_flags;
                        end
                    end
                end
            end
            c_st_mul_busy: begin
                if (!w_mul_done) begin
                    acc_d    = {w_sum, acc_q[DSIZE-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + (SHW + 1)'(1);
                end else if (w_out_free) begin
                    out_d       = acc_q[DSIZE-1:0];
                    out_valid_d = 1'b1;
                    state_d     = c_st_idle;
                    if (mupd_q) begin
                        flag_d = {acc_q[DSIZE-1:0] == '0,
                                  |acc_q[2*DSIZE-1:DSIZE],
                                  acc_q[DSIZE-1]};
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // State update; reset discards any in-flight multiply
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_st_idle;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mupd_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            flag_q      <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mupd_q      <= mupd_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            flag_q      <= flag_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign flag      = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe: directed corner cases plus
//            randomized traffic against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int DSIZE = 16;
    localparam int SHW   = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [DSIZE-1:0] a         = '0;
    logic [DSIZE-1:0] b         = '0;
    logic [3:0]       op        = '0;
    logic [SHW-1:0]   imm       = '0;
    logic             update    = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DSIZE-1:0] out;
    logic [2:0]       flag;

    alu_pipe #(.DSIZE(DSIZE), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .imm       (imm),
        .update    (update),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [2:0]  f;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [2:0] m_flag  = 3'b000;
    bit         rnd_rdy = 1'b0;
    int         n_cmp   = 0;
    int         n_bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: results from plain integer arithmetic, flags from signed
    // range checks; queued in issue order together with the flag state.
    task automatic model_push(input logic [3:0] op_v, input logic [15:0] a_v,
                              input logic [15:0] b_v, input logic [3:0] imm_v,
                              input logic upd_v);
        longint ua, ub, sa, sb, sr, r, p, pw;
        bit wr;
        logic [2:0] nf;
        exp_t e;
        ua = longint'(a_v);
        ub = longint'(b_v);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        pw = longint'(1) << imm_v;
        wr = 1'b0;
        nf = m_flag;
        r  = 0;
        case (op_v)
            4'd0: begin
                sr = sa + sb; r = (ua + ub) % 65536; wr = 1'b1;
                nf = {r == 0, (sr > 32767) || (sr < -32768), r >= 32768};
            end
            4'd1: begin
                sr = sa - sb; r = (ua - ub + 65536) % 65536; wr = 1'b1;
                nf = {r == 0, (sr > 32767) || (sr < -32768), r >= 32768};
            end
            4'd2: begin r = ua & ub; wr = 1'b1; nf = {r == 0, 1'b0, r >= 32768}; end
            4'd3: begin r = ua | ub; wr = 1'b1; nf = {r == 0, 1'b0, r >= 32768}; end
            4'd4: r = (ua * pw) % 65536;
            4'd5: r = ua / pw;
            4'd6: begin
                sr = (sa >= 0) ? sa / pw : -(((-sa) + pw - 1) / pw);
                r  = (sr + 65536) % 65536;
            end
            4'd7: r = (ua * pw) % 65536 + ua / (65536 / pw);
            4'd8: r = (ub % 256) * 256 + ua % 256;
            4'd9: r = (ua / 256) * 256 + ub % 256;
            4'd10: begin
                p = ua * ub; r = p % 65536; wr = 1'b1;
                nf = {r == 0, p >= 65536, r >= 32768};
            end
            default: r = 0;
        endcase
        if (upd_v && wr) m_flag = nf;
        e.r = r[15:0];
        e.f = m_flag;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every output transfer must match the next expected entry
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk_eq("spurious_out_valid", out_valid, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk_eq("sb_out", out, mon_e.r);
                chk_eq("sb_flag", flag, mon_e.f);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one op and hold it until accepted; returns cycles waited
    task automatic send(input logic [3:0] op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                        input logic [3:0] imm_v, input logic upd_v, output int waited);
        bit acc;
        waited   = 0;
        acc      = 1'b0;
        op       = op_v;
        a        = a_v;
        b        = b_v;
        imm      = imm_v;
        update   = upd_v;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(op_v, a_v, b_v, imm_v, upd_v);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            if (acc) break;
            waited++;
            if (waited > 200) begin
                chk_eq("accept_timeout", waited, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 100) begin
            cycles(1);
            n++;
        end
        chk_eq("drain_left", sb_q.size(), 0);
    endtask

    function automatic logic [15:0] rand16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int w, lat, seen;
        logic [3:0] r_op;

        // Reset state
        cycles(2);
        chk_eq("rst_out", out, 0);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_flag", flag, 0);
        chk_eq("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        cycles(1);

        // Back-to-back single-cycle ops
        send(4'd0, 16'h7FFF, 16'h0001, 4'd0, 1'b1, w);
        chk_eq("b2b_add_valid", out_valid, 1);
        chk_eq("b2b_add_out", out, 16'h8000);
        chk_eq("b2b_add_flag", flag, 3'b011);
        send(4'd2, 16'h00F0, 16'h0F00, 4'd0, 1'b1, w);
        chk_eq("b2b_and_wait", w, 0);
        chk_eq("b2b_and_out", out, 16'h0000);
        chk_eq("b2b_and_flag", flag, 3'b100);

        // Flags hold across shifts
        send(4'd1, 16'd5, 16'd5, 4'd0, 1'b1, w);
        send(4'd4, 16'h0001, 16'h0000, 4'd15, 1'b1, w);
        chk_eq("hold_sll_out", out, 16'h8000);
        chk_eq("hold_sll_flag", flag, 3'b100);

        // Boundaries
        send(4'd7, 16'h8001, 16'h0000, 4'd0, 1'b1, w);
        chk_eq("rl0_out", out, 16'h8001);
        send(4'd7, 16'h8001, 16'h0000, 4'd1, 1'b1, w);
        chk_eq("rl1_out", out, 16'h0003);
        send(4'd6, 16'h8000, 16'h0000, 4'd15, 1'b1, w);
        chk_eq("sra15_out", out, 16'hFFFF);
        send(4'd8, 16'h1234, 16'h00AB, 4'd0, 1'b1, w);
        chk_eq("lhb_out", out, 16'hAB34);
        send(4'd12, 16'h1234, 16'h5678, 4'd3, 1'b1, w);
        chk_eq("undef_valid", out_valid, 1);
        chk_eq("undef_out", out, 16'h0000);
        chk_eq("undef_flag", flag, 3'b100);

        // Multiply latency and busy back-pressure
        send(4'd10, 16'h0100, 16'h0100, 4'd0, 1'b1, w);
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk_eq("mul_busy_in_ready", in_ready, 0);
            cycles(1);
            lat++;
        end
        chk_eq("mul_latency", lat, 17);
        chk_eq("mul_out", out, 16'h0000);
        chk_eq("mul_flag", flag, 3'b110);
        cycles(1);

        // Output back-pressure
        out_ready = 1'b0;
        send(4'd0, 16'h1234, 16'h1111, 4'd0, 1'b0, w);
        op = 4'd3; a = 16'h0F0F; b = 16'hF000; imm = 4'd0; update = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_eq("bp_in_ready", in_ready, 0);
            chk_eq("bp_out_valid", out_valid, 1);
            chk_eq("bp_out_stable", out, 16'h2345);
            cycles(1);
        end
        out_ready = 1'b1;
        send(4'd3, 16'h0F0F, 16'hF000, 4'd0, 1'b1, w);
        chk_eq("bp_release_wait", w, 0);
        chk_eq("bp_or_out", out, 16'hFF0F);
        drain();

        // Randomized traffic with random output back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r_op = ($urandom_range(0, 5) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            send(r_op, rand16(), rand16(), 4'($urandom_range(0, 15)), 1'($urandom), w);
        end
        rnd_rdy = 1'b0;
        drain();

        // Reset in the middle of a multiply
        send(4'd1, 16'd3, 16'd5, 4'd0, 1'b1, w);
        send(4'd10, 16'hFFFF, 16'hFFFF, 4'd0, 1'b1, w);
        chk_eq("pre_rst_flag", flag, 3'b001);
        cycles(4);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("midmul_rst_out", out, 0);
        chk_eq("midmul_rst_out_valid", out_valid, 0);
        chk_eq("midmul_rst_flag", flag, 0);
        sb_q.delete();
        m_flag = 3'b000;
        #2;
        rst = 1'b1;
        cycles(1);
        chk_eq("post_rst_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen++;
            cycles(1);
        end
        chk_eq("no_stale_mul", seen, 0);
        send(4'd0, 16'd2, 16'd3, 4'd0, 1'b1, w);
        chk_eq("post_rst_add_out", out, 16'd5);
        chk_eq("post_rst_add_flag", flag, 3'b000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, parametrised successor of the combinational datapath ALU. Adds valid/ready handshakes on input and output, an iterative multi-cycle unsigned multiply (MUL), and a persistent N/V/Z flag register that holds its value between updating operations.
- Sits in the execute stage between operand fetch and writeback. Width and shift-amount size are generic.

Parameters:
- DSIZE, 16: datapath width. Must be even and >= 4.
- SHW, 4: shift/rotate amount width. Must equal clog2(DSIZE).

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand/op bundle is valid.
- in_ready, output, 1: block accepts the bundle this cycle.
- a, input, DSIZE: 1st operand.
- b, input, DSIZE: 2nd operand.
- op, input, 4: operation. ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, SRA=6, RL=7, LHB=8, LLB=9, MUL=10. Values 11-15 are undefined ops.
- imm, input, SHW: shift/rotate amount.
- update, input, 1: the flag register may be written by this op.
- out_valid, output, 1: out is valid.
- out_ready, input, 1: consumer takes out this cycle.
- out, output, DSIZE: registered result.
- flag, output, 3: registered flags {Z,V,N}. flag[2]=Z, flag[1]=V, flag[0]=N.

Behaviour:
- Reset (rst=0, asynchronous):
  - out=0, out_valid=0, flag=000, FSM returns to IDLE.
  - Any in-flight MUL is discarded and produces no output.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and gives back-to-back throughput of 1 op/cycle for single-cycle ops.
  - out and out_valid stay stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, MUL_BUSY.
  - IDLE, accept of a non-MUL op: result loads into out the same edge; out_valid=1 the next cycle (latency 1).
  - IDLE, accept of MUL: latch a, b and update; go to MUL_BUSY; in_ready=0.
  - MUL_BUSY: one shift-add step per cycle for DSIZE cycles, using a 2*DSIZE-bit accumulator.
  - End of MUL_BUSY: the product loads into out only when (!out_valid || out_ready); otherwise the FSM stays in its final step until that holds.
  - MUL latency from accept to out_valid: DSIZE+1 cycles when unstalled.
  - After the product loads, the FSM returns to IDLE.
  - A new accept is possible in the same cycle the product loads only if in_ready rules allow it. They do not, because state != IDLE in that cycle.
- Results (all arithmetic modulo 2^DSIZE; H=DSIZE/2):
  - ADD: a+b.
  - SUB: a-b.
  - AND: a&b.
  - OR: a|b.
  - SLL: a<<imm.
  - SRL: a>>imm (logical).
  - SRA: signed a>>>imm.
  - RL: rotate left by imm. imm=0 gives a; no shift by DSIZE.
  - LHB: {b[H-1:0], a[H-1:0]}.
  - LLB: {a[DSIZE-1:H], b[H-1:0]}.
  - MUL: low DSIZE bits of unsigned a*b.
  - Undefined op: out=0 with out_valid=1; flags held.
- Flags:
  - Written only on the edge the result loads into out, and only when the op's latched update=1.
  - ADD: Z=(res==0); V=(a[msb]==b[msb] && res[msb]!=a[msb]); N=res[msb].
  - SUB: Z=(res==0); V=(a[msb]!=b[msb] && res[msb]!=a[msb]); N=res[msb].
  - AND/OR: Z=(res==0); V=0; N=res[msb].
  - MUL: Z=(low==0); V=(high DSIZE bits != 0); N=low[msb].
  - Shifts, rotate, LHB, LLB, and ops with update=0: flags hold their previous value and are not cleared.

Test Plan:
- Reset: assert rst=0 mid-MUL (cycle 5 of 16) -> out=0, out_valid=0, flag=000 immediately. After release, in_ready=1 and no stale MUL result appears.
- Back-to-back: ADD 0x7FFF+0x0001 (update=1), then AND 0x00F0&0x0F00 (update=1), out_ready=1 -> out=0x8000 with flag=011 (V,N) on cycle 1; out=0x0000 with flag=100 on cycle 2.
- Flag hold: SUB 5-5 update=1, then SLL a=1 imm=15 update=1 -> out=0x8000, flag stays 100.
- MUL: a=0x0100, b=0x0100, update=1 -> out_valid exactly 17 cycles after accept, out=0x0000, flag=110. in_ready=0 throughout.
- Backpressure: out_ready=0 with one result pending -> in_ready=0 and out stable for 10 cycles. Raise out_ready -> transfer, then the next op accepts the same cycle.
- Boundaries: RL a=0x8001 imm=0 -> 0x8001; RL imm=1 -> 0x0003; SRA 0x8000 imm=15 -> 0xFFFF; LHB a=0x1234 b=0x00AB -> 0xAB34; op=12 -> out=0, flags held.
